// File: rtl/mp_bit_merge_pkg.sv
// Shared constants and helpers for the multi-port bit-merge register.
package mp_bit_merge_pkg;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Pointer width: a single-port or two-port arbiter still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mp_prio_pick.sv
// Per-bit priority pick: one-hot grant to the first requester at or after start.
module mp_prio_pick
  import mp_bit_merge_pkg::*;
#(
  parameter  int PORTS = 2,
  localparam int PTR_W = clog2_min1(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] start,
  output logic [PORTS-1:0] grant,
  output logic             multi
);

  always_comb begin
    int   slot;
    int   nreq;
    logic found;
    grant = '0;
    found = 1'b0;
    nreq  = 0;
    slot  = 0;
    for (int i = 0; i < PORTS; i++) begin
      // Walk ports in rotated order; start never exceeds PORTS-1.
      slot = int'(start) + i;
      if (slot >= PORTS) slot = slot - PORTS;
      for (int p = 0; p < PORTS; p++) begin
        if (p == slot && req[p] && !found) begin
          grant[p] = 1'b1;
          found    = 1'b1;
        end
      end
      if (req[i]) nreq = nreq + 1;
    end
    multi = (nreq > 1);
  end

endmodule

// File: rtl/mp_bit_merge_reg.sv
// Shared status/control word written bit-wise by several ports; overlapping
// writes are resolved per bit and reported, counted and optionally rotated.
module mp_bit_merge_reg
  import mp_bit_merge_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int PORTS     = 2,
  parameter  int PRIO_MODE = 0,
  parameter  int CNT_W     = 8,
  localparam int PTR_W     = clog2_min1(PORTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         wr_en,
  input  logic [0:PORTS*WIDTH-1]   wr_mask,
  input  logic [0:PORTS*WIDTH-1]   wr_data,
  input  logic                     clr_cnt,
  output logic [0:WIDTH-1]         q,
  output logic                     conflict,
  output logic [0:WIDTH-1]         conflict_bits,
  output logic [CNT_W-1:0]         conflict_cnt,
  output logic [PTR_W-1:0]         rr_ptr
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PORTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [0:WIDTH-1] nxt_q;
  logic [0:WIDTH-1] conf_vec;
  logic [PTR_W-1:0] pick_start;
  logic             any_conf;

  assign pick_start = (PRIO_MODE == PRIO_RR) ? rr_ptr : '0;
  assign any_conf   = |conf_vec;

  // Stage 0: combinational per-bit resolution of all port requests.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [PORTS-1:0] req;
    logic [PORTS-1:0] gnt;
    logic             multi;
    logic             bit_d;

    always_comb begin
      req = '0;
      for (int p = 0; p < PORTS; p++) begin
        req[p] = wr_en[p] & wr_mask[p*WIDTH + b];
      end
    end

    mp_prio_pick #(
      .PORTS (PORTS)
    ) u_pick (
      .req   (req),
      .start (pick_start),
      .grant (gnt),
      .multi (multi)
    );

    // Unrequested bits hold; otherwise the single granted port supplies data.
    always_comb begin
      bit_d = q[b];
      for (int p = 0; p < PORTS; p++) begin
        if (gnt[p]) bit_d = wr_data[p*WIDTH + b];
      end
    end

    assign nxt_q[b]    = bit_d;
    assign conf_vec[b] = multi;
  end

  // Stage 1: registered state, all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= nxt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict      <= 1'b0;
      conflict_bits <= '0;
    end else begin
      conflict      <= any_conf;
      conflict_bits <= conf_vec;
    end
  end

  // A clear drops the same-cycle conflict rather than counting it.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)                         conflict_cnt <= '0;
    else if (any_conf && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (PRIO_MODE == PRIO_RR && any_conf) begin
      rr_ptr <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_mp_bit_merge_reg.sv
// Bench for mp_bit_merge_reg: directed scenarios plus randomized traffic
// against a per-bit reference model, over fixed, round-robin and small-counter builds.
module tb_mp_bit_merge_reg;

  typedef struct {
    logic [0:7] q;
    logic [0:7] cb;
    logic       c;
    int         cnt;
    int         ptr;
  } mstate_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [0:15] wr_mask;
  logic [0:15] wr_data;
  logic        clr_cnt;
  logic [2:0]  wr_en3;
  logic [0:23] wr_mask3;
  logic [0:23] wr_data3;
  logic        clr3;

  logic [0:7] fix_q, rr_q, sat_q, r4_q;
  logic [0:7] fix_cb, rr_cb, sat_cb, r4_cb;
  logic       fix_c, rr_c, sat_c, r4_c;
  logic [7:0] fix_cnt, rr_cnt;
  logic [1:0] sat_cnt;
  logic [3:0] r4_cnt;
  logic       fix_ptr, rr_ptr_o, sat_ptr;
  logic [1:0] r4_ptr;

  mstate_t m_fix, m_rr, m_sat, m_r4;
  int n_tests = 0;
  int n_fail  = 0;
  int ptr_before;

  always #5 clk = ~clk;

  mp_bit_merge_reg #(.WIDTH(8), .PORTS(2), .PRIO_MODE(0), .CNT_W(8)) u_fix (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .clr_cnt(clr_cnt), .q(fix_q), .conflict(fix_c), .conflict_bits(fix_cb),
    .conflict_cnt(fix_cnt), .rr_ptr(fix_ptr));

  mp_bit_merge_reg #(.WIDTH(8), .PORTS(2), .PRIO_MODE(1), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .clr_cnt(clr_cnt), .q(rr_q), .conflict(rr_c), .conflict_bits(rr_cb),
    .conflict_cnt(rr_cnt), .rr_ptr(rr_ptr_o));

  mp_bit_merge_reg #(.WIDTH(8), .PORTS(2), .PRIO_MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .clr_cnt(clr_cnt), .q(sat_q), .conflict(sat_c), .conflict_bits(sat_cb),
    .conflict_cnt(sat_cnt), .rr_ptr(sat_ptr));

  mp_bit_merge_reg #(.WIDTH(8), .PORTS(3), .PRIO_MODE(1), .CNT_W(4)) u_r4 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_mask(wr_mask3), .wr_data(wr_data3),
    .clr_cnt(clr3), .q(r4_q), .conflict(r4_c), .conflict_bits(r4_cb),
    .conflict_cnt(r4_cnt), .rr_ptr(r4_ptr));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: per bit, collect requesters in priority order; first one wins.
  function automatic mstate_t model_step(input mstate_t s, input int ports, input int mode,
                                         input int cntmax, input logic r, input logic clr,
                                         input logic [3:0] en, input logic [0:31] mask,
                                         input logic [0:31] data);
    mstate_t n;
    logic any;
    n = s;
    if (r) begin
      n.q = '0; n.cb = '0; n.c = 1'b0; n.cnt = 0; n.ptr = 0;
      return n;
    end
    any = 1'b0;
    for (int b = 0; b < 8; b++) begin
      int nreq, win;
      nreq = 0; win = -1;
      for (int k = 0; k < ports; k++) begin
        int p;
        p = (s.ptr + k) % ports;
        if (en[p] && mask[p*8 + b]) begin
          nreq++;
          if (win < 0) win = p;
        end
      end
      if (win >= 0) n.q[b] = data[win*8 + b];
      n.cb[b] = (nreq > 1);
      if (nreq > 1) any = 1'b1;
    end
    n.c = any;
    if (clr) n.cnt = 0;
    else if (any && s.cnt < cntmax) n.cnt = s.cnt + 1;
    if (mode == 1 && any) n.ptr = (s.ptr + 1) % ports;
    return n;
  endfunction

  task automatic cmp(input string nm, input mstate_t m, input logic [0:7] q, input logic [0:7] cb,
                     input logic c, input int cnt, input int ptr);
    chk({nm, ".q"}, 64'(q), 64'(m.q));
    chk({nm, ".conflict_bits"}, 64'(cb), 64'(m.cb));
    chk({nm, ".conflict"}, 64'(c), 64'(m.c));
    chk({nm, ".cnt"}, 64'(cnt), 64'(m.cnt));
    chk({nm, ".rr_ptr"}, 64'(ptr), 64'(m.ptr));
  endtask

  task automatic step();
    @(posedge clk);
    m_fix = model_step(m_fix, 2, 0, 255, rst, clr_cnt, {2'b0, wr_en}, {wr_mask, 16'b0}, {wr_data, 16'b0});
    m_rr  = model_step(m_rr,  2, 1, 255, rst, clr_cnt, {2'b0, wr_en}, {wr_mask, 16'b0}, {wr_data, 16'b0});
    m_sat = model_step(m_sat, 2, 0, 3,   rst, clr_cnt, {2'b0, wr_en}, {wr_mask, 16'b0}, {wr_data, 16'b0});
    m_r4  = model_step(m_r4,  3, 1, 15,  rst, clr3, {1'b0, wr_en3}, {wr_mask3, 8'b0}, {wr_data3, 8'b0});
    #1;
    cmp("fix", m_fix, fix_q, fix_cb, fix_c, int'(fix_cnt), int'(fix_ptr));
    cmp("rr",  m_rr,  rr_q,  rr_cb,  rr_c,  int'(rr_cnt),  int'(rr_ptr_o));
    cmp("sat", m_sat, sat_q, sat_cb, sat_c, int'(sat_cnt), int'(sat_ptr));
    cmp("r4",  m_r4,  r4_q,  r4_cb,  r4_c,  int'(r4_cnt),  int'(r4_ptr));
  endtask

  task automatic set_overlap();
    wr_en   = 2'b11;
    wr_mask = {8'b1111_0000, 8'b0001_1111};
    wr_data = {8'hFF, 8'h00};
  endtask

  initial begin
    m_fix = '{q: '0, cb: '0, c: 1'b0, cnt: 0, ptr: 0};
    m_rr = m_fix; m_sat = m_fix; m_r4 = m_fix;
    rst = 1'b1; clr_cnt = 1'b0; wr_en = '0; wr_mask = '0; wr_data = '0;
    clr3 = 1'b0; wr_en3 = '0; wr_mask3 = '0; wr_data3 = '0;
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    chk("idle.q", 64'(fix_q), 64'h0);
    chk("idle.conflict", 64'(fix_c), 64'h0);
    chk("idle.cnt", 64'(fix_cnt), 64'h0);

    set_overlap();
    step();
    chk("m0.q", 64'(fix_q), 64'(8'b1111_0000));
    chk("m0.conflict_bits", 64'(fix_cb), 64'(8'b0001_0000));
    chk("m0.conflict", 64'(fix_c), 64'h1);
    chk("m0.cnt", 64'(fix_cnt), 64'h1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 3) begin
        chk("rr.q3", 64'(rr_q[3]), (i % 2 == 0) ? 64'h1 : 64'h0);
        chk("rr.ptr", 64'(rr_ptr_o), (i % 2 == 0) ? 64'h1 : 64'h0);
      end
      if (i == 2) chk("rr.cnt3", 64'(rr_cnt), 64'h3);
      chk("sat.cnt", 64'(sat_cnt), (i < 3) ? 64'(i + 1) : 64'h3);
    end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("sat.clr_cnt", 64'(sat_cnt), 64'h0);
    chk("sat.clr_conflict", 64'(sat_c), 64'h1);

    wr_en = 2'b01; wr_mask = 16'hFF00; wr_data = 16'h0000;
    step();
    ptr_before = int'(rr_ptr_o);
    wr_en = 2'b11; wr_mask = {8'b1110_0000, 8'b0000_0111}; wr_data = 16'hFFFF;
    step();
    chk("disj.q", 64'(fix_q), 64'(8'b1110_0111));
    chk("disj.conflict", 64'(fix_c), 64'h0);
    chk("disj.rr_ptr", 64'(rr_ptr_o), 64'(ptr_before));

    set_overlap();
    step();
    rst = 1'b1;
    step();
    chk("mrst.q", 64'(rr_q), 64'h0);
    chk("mrst.cnt", 64'(rr_cnt), 64'h0);
    chk("mrst.ptr", 64'(rr_ptr_o), 64'h0);
    rst = 1'b0;
    step();
    chk("mrst.after_q", 64'(fix_q), 64'(8'b1111_0000));
    chk("mrst.after_cnt", 64'(fix_cnt), 64'h1);
    chk("mrst.after_ptr", 64'(rr_ptr_o), 64'h1);

    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      clr_cnt  = ($urandom_range(0, 19) == 0);
      clr3     = ($urandom_range(0, 19) == 0);
      wr_en    = 2'($urandom_range(0, 3));
      wr_mask  = 16'($urandom);
      wr_data  = 16'($urandom);
      wr_en3   = 3'($urandom_range(0, 7));
      wr_mask3 = 24'($urandom);
      wr_data3 = 24'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
